he_lb_csr_sequencer: RTL and testbench

//  Hardware sequencer that programs and runs one HE-LB memory loopback pass over a simple MMIO master port.

---
 rtl/he_lb_seq_pkg.sv | 70 +++++++
 rtl/he_lb_seq_poll_timer.sv | 35 +++
 rtl/he_lb_csr_sequencer.sv | 251 +++++++++++++++++++++++++
 tb/tb_he_lb_csr_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/he_lb_seq_pkg.sv
// Shared HE-LB CSR map, control encodings and sequencer types.
// The DFH states exist only when HE_LB_SEQ_DFH_CHECK_EN is defined.
package he_lb_seq_pkg;

  localparam logic [11:0] OFF_DFH       = 12'h000;
  localparam logic [11:0] OFF_DSM_BASEL = 12'h110;
  localparam logic [11:0] OFF_DSM_BASEH = 12'h114;
  localparam logic [11:0] OFF_SRC_ADDR  = 12'h120;
  localparam logic [11:0] OFF_DST_ADDR  = 12'h128;
  localparam logic [11:0] OFF_NUM_LINES = 12'h130;
  localparam logic [11:0] OFF_CTL       = 12'h138;
  localparam logic [11:0] OFF_CFG       = 12'h140;
  localparam logic [11:0] OFF_STATUS0   = 12'h160;
  localparam logic [11:0] OFF_ERROR     = 12'h170;

  localparam logic [63:0] CTL_RST   = 64'h0;
  localparam logic [63:0] CTL_EN    = 64'h1;
  localparam logic [63:0] CTL_START = 64'h3;
  localparam logic [63:0] CTL_STOP  = 64'h7;

  localparam logic [3:0] WR_LAST       = 4'd8;
  localparam logic [3:0] AFU_FEAT_TYPE = 4'h1;

  typedef enum logic [3:0] {
    S_IDLE,
`ifdef HE_LB_SEQ_DFH_CHECK_EN
    S_DFH_RD,
    S_DFH_WAIT,
`endif
    S_WR,
    S_POLL_RD,
    S_POLL_WAIT,
    S_POLL_GAP,
    S_ERR_RD,
    S_ERR_WAIT,
    S_STOP,
    S_DONE
  } t_seq_state;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_ZERO    = 3'd1,
    ERR_TIMEOUT = 3'd2,
    ERR_AFU     = 3'd3,
    ERR_DFH     = 3'd4
  } t_seq_err;

  typedef struct packed {
    logic [3:0]  feat_type;
    logic [18:0] rsvd;
    logic        eol;
    logic [23:0] next_offset;
    logic [3:0]  feat_rev;
    logic [11:0] feat_id;
  } t_dfh;

  // Byte offset of each entry in the programming table; 6..8 all hit CTL.
  function automatic logic [11:0] wr_offset(input logic [3:0] idx);
    case (idx)
      4'd0:    wr_offset = OFF_DSM_BASEL;
      4'd1:    wr_offset = OFF_DSM_BASEH;
      4'd2:    wr_offset = OFF_SRC_ADDR;
      4'd3:    wr_offset = OFF_DST_ADDR;
      4'd4:    wr_offset = OFF_NUM_LINES;
      4'd5:    wr_offset = OFF_CFG;
      default: wr_offset = OFF_CTL;
    endcase
  endfunction

endpackage

// File: rtl/he_lb_seq_poll_timer.sv
// STATUS0 poll pacing: inter-poll gap down-counter and a saturating poll-attempt counter.
module he_lb_seq_poll_timer #(
  parameter int POLL_GAP  = 64,
  parameter int TIMEOUT_W = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic start,
  output logic expire,
  output logic timeout
);

  localparam int GAP_W = (POLL_GAP < 2) ? 1 : $clog2(POLL_GAP);

  logic [GAP_W-1:0]     gap_cnt;
  logic [TIMEOUT_W-1:0] attempts;

  // Loading POLL_GAP-1 and leaving at zero gives exactly POLL_GAP gap cycles.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      gap_cnt  <= '0;
      attempts <= '0;
    end else if (start) begin
      gap_cnt <= GAP_W'(POLL_GAP - 1);
      if (!timeout) attempts <= attempts + 1'b1;
    end else if (gap_cnt != '0) begin
      gap_cnt <= gap_cnt - 1'b1;
    end
  end

  assign expire  = (gap_cnt == '0);
  assign timeout = &attempts;

endmodule

// File: rtl/he_lb_csr_sequencer.sv
// Programs and runs one HE-LB loopback pass over an MMIO master port.
// Optional DFH feature-type check: define HE_LB_SEQ_DFH_CHECK_EN.
module he_lb_csr_sequencer
  import he_lb_seq_pkg::*;
#(
  parameter int ADDR_W    = 20,
  parameter int POLL_GAP  = 64,
  parameter int TIMEOUT_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [63:0]       cmd_src,
  input  logic [63:0]       cmd_dst,
  input  logic [63:0]       cmd_dsm,
  input  logic [31:0]       cmd_num_lines,
  input  logic [63:0]       cmd_cfg,
  output logic              csr_wr_valid,
  input  logic              csr_wr_ready,
  output logic [ADDR_W-1:0] csr_addr,
  output logic [63:0]       csr_wdata,
  output logic              csr_wr_len32,
  output logic              csr_rd_valid,
  input  logic              csr_rd_ready,
  input  logic              csr_rsp_valid,
  input  logic [63:0]       csr_rsp_data,
  output logic              busy,
  output logic              done,
  output logic [2:0]        err_code,
  output logic [63:0]       err_reg
);

  t_seq_state  state;
  logic [3:0]  idx;
  logic [3:0]  nxt_idx;
  logic [63:0] src_r;
  logic [63:0] dst_r;
  logic [63:0] dsm_r;
  logic [63:0] cfg_r;
  logic [31:0] nl_r;
  logic        accept;
  logic        poll_hit;
  logic        poll_start;
  logic        gap_expire;
  logic        poll_timeout;

  assign accept     = cmd_valid && cmd_ready;
  assign nxt_idx    = idx + 4'd1;
  assign poll_hit   = (csr_rsp_data[31:0] == nl_r);
  assign poll_start = (state == S_POLL_WAIT) && csr_rsp_valid && !poll_hit;

`ifdef HE_LB_SEQ_DFH_CHECK_EN
  t_dfh dfh;
  assign dfh = t_dfh'(csr_rsp_data);
`endif

  function automatic logic [ADDR_W-1:0] to_addr(input logic [11:0] off);
    to_addr = ADDR_W'(off);
  endfunction

  function automatic logic [63:0] wr_data(input logic [3:0]  i,
                                          input logic [63:0] dsm,
                                          input logic [63:0] src,
                                          input logic [63:0] dst,
                                          input logic [31:0] nl,
                                          input logic [63:0] cfg);
    case (i)
      4'd0:    wr_data = {32'h0, dsm[31:0]};
      4'd1:    wr_data = {32'h0, dsm[63:32]};
      4'd2:    wr_data = src;
      4'd3:    wr_data = dst;
      4'd4:    wr_data = {32'h0, nl};
      4'd5:    wr_data = cfg;
      4'd6:    wr_data = CTL_RST;
      4'd7:    wr_data = CTL_EN;
      default: wr_data = CTL_START;
    endcase
  endfunction

  he_lb_seq_poll_timer #(
    .POLL_GAP  (POLL_GAP),
    .TIMEOUT_W (TIMEOUT_W)
  ) u_poll_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .start   (poll_start),
    .expire  (gap_expire),
    .timeout (poll_timeout)
  );

  // Command payload is pure data: captured on accept, never reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      src_r <= cmd_src;
      dst_r <= cmd_dst;
      dsm_r <= cmd_dsm;
      cfg_r <= cmd_cfg;
      nl_r  <= cmd_num_lines;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      idx          <= '0;
      cmd_ready    <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      err_code     <= ERR_NONE;
      err_reg      <= '0;
      csr_wr_valid <= 1'b0;
      csr_rd_valid <= 1'b0;
      csr_addr     <= '0;
      csr_wdata    <= '0;
      csr_wr_len32 <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            err_code  <= ERR_NONE;
            idx       <= '0;
            if (cmd_num_lines == '0) begin
              err_code <= ERR_ZERO;
              done     <= 1'b1;
              state    <= S_DONE;
            end else begin
`ifdef HE_LB_SEQ_DFH_CHECK_EN
              csr_rd_valid <= 1'b1;
              csr_addr     <= to_addr(OFF_DFH);
              state        <= S_DFH_RD;
`else
              csr_wr_valid <= 1'b1;
              csr_addr     <= to_addr(wr_offset(4'd0));
              csr_wdata    <= wr_data(4'd0, cmd_dsm, cmd_src, cmd_dst, cmd_num_lines, cmd_cfg);
              csr_wr_len32 <= 1'b1;
              state        <= S_WR;
`endif
            end
          end
        end
`ifdef HE_LB_SEQ_DFH_CHECK_EN
        S_DFH_RD: begin
          if (csr_rd_ready) begin
            csr_rd_valid <= 1'b0;
            state        <= S_DFH_WAIT;
          end
        end
        S_DFH_WAIT: begin
          if (csr_rsp_valid) begin
            if (dfh.feat_type == AFU_FEAT_TYPE) begin
              csr_wr_valid <= 1'b1;
              csr_addr     <= to_addr(wr_offset(4'd0));
              csr_wdata    <= wr_data(4'd0, dsm_r, src_r, dst_r, nl_r, cfg_r);
              csr_wr_len32 <= 1'b1;
              state        <= S_WR;
            end else begin
              err_code <= ERR_DFH;
              done     <= 1'b1;
              state    <= S_DONE;
            end
          end
        end
`endif
        S_WR: begin
          if (csr_wr_ready) begin
            if (idx == WR_LAST) begin
              csr_wr_valid <= 1'b0;
              csr_wr_len32 <= 1'b0;
              csr_rd_valid <= 1'b1;
              csr_addr     <= to_addr(OFF_STATUS0);
              state        <= S_POLL_RD;
            end else begin
              idx          <= nxt_idx;
              csr_addr     <= to_addr(wr_offset(nxt_idx));
              csr_wdata    <= wr_data(nxt_idx, dsm_r, src_r, dst_r, nl_r, cfg_r);
              csr_wr_len32 <= (idx == 4'd0);
            end
          end
        end
        S_POLL_RD: begin
          if (csr_rd_ready) begin
            csr_rd_valid <= 1'b0;
            state        <= S_POLL_WAIT;
          end
        end
        S_POLL_WAIT: begin
          if (csr_rsp_valid) begin
            if (poll_hit) begin
              csr_rd_valid <= 1'b1;
              csr_addr     <= to_addr(OFF_ERROR);
              state        <= S_ERR_RD;
            end else begin
              state <= S_POLL_GAP;
            end
          end
        end
        S_POLL_GAP: begin
          // Timeout skips the ERROR read and goes straight to stopping the engine.
          if (poll_timeout) begin
            err_code     <= ERR_TIMEOUT;
            csr_wr_valid <= 1'b1;
            csr_addr     <= to_addr(OFF_CTL);
            csr_wdata    <= CTL_STOP;
            csr_wr_len32 <= 1'b0;
            state        <= S_STOP;
          end else if (gap_expire) begin
            csr_rd_valid <= 1'b1;
            csr_addr     <= to_addr(OFF_STATUS0);
            state        <= S_POLL_RD;
          end
        end
        S_ERR_RD: begin
          if (csr_rd_ready) begin
            csr_rd_valid <= 1'b0;
            state        <= S_ERR_WAIT;
          end
        end
        S_ERR_WAIT: begin
          if (csr_rsp_valid) begin
            err_reg      <= csr_rsp_data;
            err_code     <= (csr_rsp_data != '0) ? ERR_AFU : ERR_NONE;
            csr_wr_valid <= 1'b1;
            csr_addr     <= to_addr(OFF_CTL);
            csr_wdata    <= CTL_STOP;
            csr_wr_len32 <= 1'b0;
            state        <= S_STOP;
          end
        end
        S_STOP: begin
          if (csr_wr_ready) begin
            csr_wr_valid <= 1'b0;
            done         <= 1'b1;
            state        <= S_DONE;
          end
        end
        S_DONE: begin
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_he_lb_csr_sequencer.sv
// Directed bench for he_lb_csr_sequencer with a reactive MMIO slave model.
`timescale 1ns/1ps
module tb_he_lb_csr_sequencer;

  localparam int ADDR_W    = 20;
  localparam int POLL_GAP  = 4;
  localparam int TIMEOUT_W = 4;
`ifdef HE_LB_SEQ_DFH_CHECK_EN
  localparam int EXP_DFH = 1;
`else
  localparam int EXP_DFH = 0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [63:0]       cmd_src = '0;
  logic [63:0]       cmd_dst = '0;
  logic [63:0]       cmd_dsm = '0;
  logic [31:0]       cmd_num_lines = '0;
  logic [63:0]       cmd_cfg = '0;
  logic              csr_wr_valid;
  logic              csr_wr_ready = 1'b1;
  logic [ADDR_W-1:0] csr_addr;
  logic [63:0]       csr_wdata;
  logic              csr_wr_len32;
  logic              csr_rd_valid;
  logic              csr_rd_ready = 1'b1;
  logic              csr_rsp_valid = 1'b0;
  logic [63:0]       csr_rsp_data = '0;
  logic              busy;
  logic              done;
  logic [2:0]        err_code;
  logic [63:0]       err_reg;

  always #5 clk = ~clk;

  he_lb_csr_sequencer #(
    .ADDR_W    (ADDR_W),
    .POLL_GAP  (POLL_GAP),
    .TIMEOUT_W (TIMEOUT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_src       (cmd_src),
    .cmd_dst       (cmd_dst),
    .cmd_dsm       (cmd_dsm),
    .cmd_num_lines (cmd_num_lines),
    .cmd_cfg       (cmd_cfg),
    .csr_wr_valid  (csr_wr_valid),
    .csr_wr_ready  (csr_wr_ready),
    .csr_addr      (csr_addr),
    .csr_wdata     (csr_wdata),
    .csr_wr_len32  (csr_wr_len32),
    .csr_rd_valid  (csr_rd_valid),
    .csr_rd_ready  (csr_rd_ready),
    .csr_rsp_valid (csr_rsp_valid),
    .csr_rsp_data  (csr_rsp_data),
    .busy          (busy),
    .done          (done),
    .err_code      (err_code),
    .err_reg       (err_reg)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Slave model state
  logic        bp_en = 1'b0;
  int          ok_at = 3;
  logic [63:0] err_val = '0;
  logic [63:0] dfh_val = 64'h1000_0000_0000_0000;
  logic [31:0] nl_exp = '0;
  logic [19:0] wa [0:31];
  logic [63:0] wd [0:31];
  logic        wl [0:31];
  int          wn = 0;
  int          poll_n = 0;
  int          err_n = 0;
  int          dfh_n = 0;
  int          bad_rd = 0;
  int          stab_err = 0;
  int          poll_t [0:31];
  int          ncyc = 0;
  logic        wr_hold = 1'b0;
  logic [19:0] hold_addr = '0;
  logic [63:0] hold_data = '0;
  logic        rsp_pend = 1'b0;
  logic [63:0] rsp_q = '0;

  // Ready is decided on the negedge, so valid&&ready here is the handshake of the next posedge.
  initial begin
    forever begin
      @(negedge clk);
      ncyc++;
      csr_rsp_valid = 1'b0;
      if (rsp_pend) begin
        csr_rsp_valid = 1'b1;
        csr_rsp_data  = rsp_q;
        rsp_pend      = 1'b0;
      end
      if (wr_hold && (csr_wr_valid !== 1'b1 || csr_addr !== hold_addr || csr_wdata !== hold_data))
        stab_err++;
      csr_wr_ready = bp_en ? ($urandom_range(0, 9) < 3) : 1'b1;
      csr_rd_ready = 1'b1;
      wr_hold   = csr_wr_valid && !csr_wr_ready;
      hold_addr = csr_addr;
      hold_data = csr_wdata;
      if (csr_wr_valid && csr_wr_ready) begin
        if (wn < 32) begin
          wa[wn] = csr_addr;
          wd[wn] = csr_wdata;
          wl[wn] = csr_wr_len32;
        end
        wn++;
      end
      if (csr_rd_valid && csr_rd_ready) begin
        rsp_pend = 1'b1;
        case (csr_addr)
          20'h000: begin dfh_n++; rsp_q = dfh_val; end
          20'h160: begin
            poll_n++;
            if (poll_n < 32) poll_t[poll_n] = ncyc;
            rsp_q = {32'hDEAD_BEEF, (ok_at != 0 && poll_n >= ok_at) ? nl_exp : 32'h0};
          end
          20'h170: begin err_n++; rsp_q = err_val; end
          default: begin bad_rd++; rsp_q = '0; end
        endcase
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [31:0] nl, input logic [63:0] dsm, input logic [63:0] src,
                       input logic [63:0] dst, input logic [63:0] cfg);
    @(negedge clk);
    wn = 0; poll_n = 0; err_n = 0; dfh_n = 0; bad_rd = 0; stab_err = 0;
    nl_exp = nl;
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid     = 1'b1;
    cmd_num_lines = nl;
    cmd_dsm       = dsm;
    cmd_src       = src;
    cmd_dst       = dst;
    cmd_cfg       = cfg;
  endtask

  task automatic wait_done(input bit poke, output int lat);
    bit got;
    got = 1'b0;
    lat = -1;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      if (poke && i < 3) begin
        cmd_valid     = 1'b1;
        cmd_num_lines = 32'd99;
        cmd_src       = 64'hBAD0_BAD0;
      end else begin
        cmd_valid = 1'b0;
      end
      if (done === 1'b1) begin
        got = 1'b1;
        lat = i;
      end
    end
    cmd_valid = 1'b0;
    chk("done_seen", got, 1);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("cmd_ready_after_done", cmd_ready, 1);
    chk("busy_after_done", busy, 0);
  endtask

  task automatic check_writes(input logic [31:0] nl, input logic [63:0] dsm, input logic [63:0] src,
                              input logic [63:0] dst, input logic [63:0] cfg);
    logic [19:0] ea [0:9];
    logic [63:0] ed [0:9];
    ea = '{20'h110, 20'h114, 20'h120, 20'h128, 20'h130, 20'h140, 20'h138, 20'h138, 20'h138, 20'h138};
    ed = '{{32'h0, dsm[31:0]}, {32'h0, dsm[63:32]}, src, dst, {32'h0, nl}, cfg,
           64'h0, 64'h1, 64'h3, 64'h7};
    chk("wr_count", wn, 10);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("wr%0d_addr", i), wa[i], ea[i]);
      chk($sformatf("wr%0d_data", i), wd[i], ed[i]);
      chk($sformatf("wr%0d_len32", i), wl[i], (i < 2) ? 1 : 0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_wr_valid"}, csr_wr_valid, 0);
    chk({tag, "_rd_valid"}, csr_rd_valid, 0);
    chk({tag, "_addr"}, csr_addr, 0);
    chk({tag, "_wdata"}, csr_wdata, 0);
    chk({tag, "_len32"}, csr_wr_len32, 0);
    chk({tag, "_err_code"}, err_code, 0);
    chk({tag, "_err_reg"}, err_reg, 0);
  endtask

  initial begin
    int lat;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;

    // Nominal, with cmd_valid poked while busy
    ok_at = 3; err_val = '0;
    issue(32'd16, 64'h1111_2222_3333_4444, 64'hA000_0000_0000_1000, 64'hB000_0000_0000_2000, 64'h0000_0000_0000_00C5);
    wait_done(1'b1, lat);
    check_writes(32'd16, 64'h1111_2222_3333_4444, 64'hA000_0000_0000_1000, 64'hB000_0000_0000_2000, 64'h0000_0000_0000_00C5);
    chk("nom_polls", poll_n, 3);
    chk("nom_err_reads", err_n, 1);
    chk("nom_dfh_reads", dfh_n, EXP_DFH);
    chk("nom_bad_reads", bad_rd, 0);
    chk("nom_err_code", err_code, 0);
    chk("nom_err_reg", err_reg, 0);

    // Write backpressure
    bp_en = 1'b1;
    issue(32'd7, 64'hDEAD_0001_BEEF_0002, 64'h0000_1234_5678_0000, 64'h0000_8765_4321_0000, 64'h5A);
    wait_done(1'b0, lat);
    bp_en = 1'b0;
    check_writes(32'd7, 64'hDEAD_0001_BEEF_0002, 64'h0000_1234_5678_0000, 64'h0000_8765_4321_0000, 64'h5A);
    chk("bp_stable", stab_err, 0);
    chk("bp_err_code", err_code, 0);

    // Zero lines
    issue(32'd0, 64'h1, 64'h2, 64'h3, 64'h4);
    wait_done(1'b0, lat);
    chk("zero_latency", lat, 0);
    chk("zero_writes", wn, 0);
    chk("zero_polls", poll_n, 0);
    chk("zero_err_reads", err_n, 0);
    chk("zero_dfh_reads", dfh_n, 0);
    chk("zero_err_code", err_code, 1);

    // Timeout: 15 polls, POLL_GAP+2 cycles apart with ready=1 and 1-cycle read latency
    ok_at = 0;
    issue(32'd16, 64'h10, 64'h20, 64'h30, 64'h40);
    wait_done(1'b0, lat);
    check_writes(32'd16, 64'h10, 64'h20, 64'h30, 64'h40);
    chk("to_polls", poll_n, 15);
    chk("to_spacing", poll_t[2] - poll_t[1], POLL_GAP + 2);
    chk("to_spacing_last", poll_t[15] - poll_t[14], POLL_GAP + 2);
    chk("to_err_reads", err_n, 0);
    chk("to_err_code", err_code, 2);

    // AFU error
    ok_at = 1; err_val = 64'h4;
    issue(32'd3, 64'h100, 64'h200, 64'h300, 64'h400);
    wait_done(1'b0, lat);
    chk("afu_polls", poll_n, 1);
    chk("afu_err_reads", err_n, 1);
    chk("afu_err_reg", err_reg, 64'h4);
    chk("afu_err_code", err_code, 3);

    // Reset in the middle of polling
    ok_at = 0; err_val = '0;
    issue(32'd8, 64'h5, 64'h6, 64'h7, 64'h8);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 500 && poll_n < 2; i++) @(negedge clk);
    chk("mid_polls_reached", poll_n, 2);
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    ok_at = 3;
    issue(32'd16, 64'hCAFE_F00D_0000_0040, 64'h7000, 64'h8000, 64'h3);
    wait_done(1'b0, lat);
    check_writes(32'd16, 64'hCAFE_F00D_0000_0040, 64'h7000, 64'h8000, 64'h3);
    chk("post_rst_polls", poll_n, 3);
    chk("post_rst_err_code", err_code, 0);

`ifdef HE_LB_SEQ_DFH_CHECK_EN
    dfh_val = 64'h3000_0000_0000_0000;
    issue(32'd16, 64'h1, 64'h2, 64'h3, 64'h4);
    wait_done(1'b0, lat);
    chk("dfh_bad_reads", dfh_n, 1);
    chk("dfh_bad_writes", wn, 0);
    chk("dfh_bad_polls", poll_n, 0);
    chk("dfh_bad_err_code", err_code, 4);
    dfh_val = 64'h1000_0000_0000_0000;
    issue(32'd16, 64'h11, 64'h22, 64'h33, 64'h44);
    wait_done(1'b0, lat);
    check_writes(32'd16, 64'h11, 64'h22, 64'h33, 64'h44);
    chk("dfh_ok_reads", dfh_n, 1);
    chk("dfh_ok_err_code", err_code, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
